// File: rtl/video_pattern_generator_if.sv
// Registered video output bus of the test pattern generator: RGB pixel, DE, syncs and frame markers.
// The master drives every signal; the slave (a sink or a checker) only observes.
interface video_pattern_generator_if #(
    parameter int COMPONENT_BITS = 8
);
    logic [3*COMPONENT_BITS-1:0] video_data;
    logic                        video_de;
    logic                        video_hsync;
    logic                        video_vsync;
    logic                        frame_start;
    logic [15:0]                 frame_count;

    modport master (
        output video_data, video_de, video_hsync, video_vsync, frame_start, frame_count
    );

    modport slave (
        input video_data, video_de, video_hsync, video_vsync, frame_start, frame_count
    );
endinterface

// File: rtl/video_pattern_generator.sv
// Multi-mode video test pattern generator (bars, ramps, checker, solid, scrolling bars).
// Optional centre crosshair overlay: define TPG_CROSSHAIR_EN.
module video_pattern_generator #(
    parameter int HSYNC          = 40,
    parameter int HBACK          = 220,
    parameter int HACTIVE        = 1280,
    parameter int HFRONT         = 110,
    parameter int VSYNC          = 5,
    parameter int VBACK          = 20,
    parameter int VACTIVE        = 720,
    parameter int VFRONT         = 5,
    parameter int COMPONENT_BITS = 8,
    parameter int HSYNC_POL      = 1,
    parameter int VSYNC_POL      = 1,
    parameter int CHECKER_LOG2   = 5,
    parameter int SCROLL_STEP    = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [2:0]                    mode,
    input  logic [3*COMPONENT_BITS-1:0]   solid_color,
    video_pattern_generator_if.master     video
);

    localparam int HTOTAL = HSYNC + HBACK + HACTIVE + HFRONT;
    localparam int VTOTAL = VSYNC + VBACK + VACTIVE + VFRONT;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int CB     = COMPONENT_BITS;
    localparam int PW     = 3 * CB;

    localparam logic [HW-1:0] H_LAST      = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(HSYNC);
    localparam logic [HW-1:0] H_ACT_START = HW'(HSYNC + HBACK);
    localparam logic [HW-1:0] H_ACT_END   = HW'(HSYNC + HBACK + HACTIVE);
    localparam logic [VW-1:0] V_LAST      = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(VSYNC);
    localparam logic [VW-1:0] V_ACT_START = VW'(VSYNC + VBACK);
    localparam logic [VW-1:0] V_ACT_END   = VW'(VSYNC + VBACK + VACTIVE);
    localparam logic [HW:0]   H_ACT_EXT   = (HW+1)'(HACTIVE);
    localparam logic [HW:0]   STEP_EXT    = (HW+1)'(SCROLL_STEP);
    localparam logic          HPOL        = (HSYNC_POL != 0);
    localparam logic          VPOL        = (VSYNC_POL != 0);

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [2:0]    mode_q;
    logic [PW-1:0] color_q;
    logic [HW-1:0] scroll_offset;
    logic [15:0]   frame_count_r;

    logic          frame_end;
    logic          de_c;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic [HW:0]   xs_sum;
    logic [HW-1:0] xs;
    logic [HW:0]   off_sum;
    logic [CB-1:0] ramp_x;
    logic [CB-1:0] ramp_y;
    logic [PW-1:0] pix_c;
    logic [PW-1:0] pix_o;

    // Bar index is the number of bar boundaries HACTIVE*k/7 at or below px.
    function automatic logic [2:0] bar_rgb(input logic [HW-1:0] px);
        int idx;
        idx = 0;
        for (int k = 1; k < 7; k++) begin
            if (32'(px) >= 32'(HACTIVE * k / 7)) idx++;
        end
        case (idx)
            0:       return 3'b111;
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b010;
            4:       return 3'b011;
            5:       return 3'b001;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [PW-1:0] expand(input logic [2:0] rgb);
        return {{CB{rgb[2]}}, {CB{rgb[1]}}, {CB{rgb[0]}}};
    endfunction

    assign frame_end = (hcount == H_LAST) && (vcount == V_LAST);
    assign de_c      = (hcount >= H_ACT_START) && (hcount < H_ACT_END) &&
                       (vcount >= V_ACT_START) && (vcount < V_ACT_END);
    assign x         = hcount - H_ACT_START;
    assign y         = vcount - V_ACT_START;
    assign ramp_x    = CB'(x);
    assign ramp_y    = CB'(y);

    // Both operands are below HACTIVE, so a single conditional subtract is the modulo.
    assign xs_sum  = {1'b0, x} + {1'b0, scroll_offset};
    assign xs      = HW'((xs_sum >= H_ACT_EXT) ? (xs_sum - H_ACT_EXT) : xs_sum);
    assign off_sum = {1'b0, scroll_offset} + STEP_EXT;

    always_comb begin
        pix_c = '0;
        case (mode_q)
            3'd0:    pix_c = expand(bar_rgb(x));
            3'd1:    pix_c = {3{ramp_x}};
            3'd2:    pix_c = {3{ramp_y}};
            3'd3:    pix_c = (x[CHECKER_LOG2] ^ y[CHECKER_LOG2]) ? '1 : '0;
            3'd4:    pix_c = color_q;
            3'd5:    pix_c = expand(bar_rgb(xs));
            default: pix_c = '0;
        endcase
    end

`ifdef TPG_CROSSHAIR_EN
    localparam logic [HW-1:0] X_MID = HW'(HACTIVE / 2);
    localparam logic [VW-1:0] Y_MID = VW'(VACTIVE / 2);

    // Inverting black (modes 6/7) yields the white crosshair there as well.
    always_comb begin
        pix_o = pix_c;
        if ((x == X_MID) || (y == Y_MID)) pix_o = ~pix_c;
    end
`else
    assign pix_o = pix_c;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hcount        <= '0;
            vcount        <= '0;
            mode_q        <= '0;
            color_q       <= '0;
            scroll_offset <= '0;
            frame_count_r <= '0;
        end else begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
            end else begin
                hcount <= hcount + HW'(1);
            end
            if (frame_end) begin
                mode_q        <= mode;
                color_q       <= solid_color;
                frame_count_r <= frame_count_r + 16'd1;
                scroll_offset <= HW'((off_sum >= H_ACT_EXT) ? (off_sum - H_ACT_EXT) : off_sum);
            end
        end
    end

    // Outputs describe the (hcount, vcount) position of the previous cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            video.video_data  <= '0;
            video.video_de    <= 1'b0;
            video.video_hsync <= ~HPOL;
            video.video_vsync <= ~VPOL;
            video.frame_start <= 1'b0;
        end else begin
            video.video_data  <= de_c ? pix_o : '0;
            video.video_de    <= de_c;
            video.video_hsync <= (hcount < H_SYNC_END) ? HPOL : ~HPOL;
            video.video_vsync <= (vcount < V_SYNC_END) ? VPOL : ~VPOL;
            video.frame_start <= (hcount == '0) && (vcount == '0);
        end
    end

    assign video.frame_count = frame_count_r;

endmodule
